// File: rtl/pcie_board_sequencer.sv
// pcie_board_sequencer
//   Board-level glue between PCIe/HBM card pins and the block design.
//   - Combinational RX/TX lane map, optionally reversed.
//   - PERST filter: 2-flop synchroniser plus debounce counter.
//   - Staggered release of NUM_DOMAINS active-low resets once the link is up.
//   - Sticky HBM catastrophic-trip output.
// Ports
//   aclk_i, aresetn_i              system clock, async active-low reset
//   perst_n_pin_i                  raw PCIE_PERST (asynchronous)
//   rx_p/n_pin_i  -> rx_p/n_core_o mapped RX lanes
//   tx_p/n_core_i -> tx_p/n_pin_o  mapped TX lanes
//   link_up_i                      PCIe core link-up
//   hbm_trip_i, cattrip_clear_i    HBM trip flags, one-cycle clear request
//   hbm_cattrip_o                  sticky trip
//   dom_rst_n_o                    per-domain active-low resets
//   seq_state_o                    0 reset, 1 wait link, 2 release, 3 run
module pcie_board_sequencer #(
   parameter int unsigned NUM_LANES       = 16,
   parameter int unsigned LANE_REVERSE    = 1,
   parameter int unsigned NUM_HBM_STACKS  = 2,
   parameter int unsigned NUM_DOMAINS     = 3,
   parameter int unsigned DEBOUNCE_CYCLES = 256,
   parameter int unsigned STAGGER_CYCLES  = 16
) (
   input  logic                      aclk_i,
   input  logic                      aresetn_i,
   input  logic                      perst_n_pin_i,
   input  logic [NUM_LANES-1:0]      rx_p_pin_i,
   input  logic [NUM_LANES-1:0]      rx_n_pin_i,
   output logic [NUM_LANES-1:0]      rx_p_core_o,
   output logic [NUM_LANES-1:0]      rx_n_core_o,
   input  logic [NUM_LANES-1:0]      tx_p_core_i,
   input  logic [NUM_LANES-1:0]      tx_n_core_i,
   output logic [NUM_LANES-1:0]      tx_p_pin_o,
   output logic [NUM_LANES-1:0]      tx_n_pin_o,
   input  logic                      link_up_i,
   input  logic [NUM_HBM_STACKS-1:0] hbm_trip_i,
   input  logic                      cattrip_clear_i,
   output logic                      hbm_cattrip_o,
   output logic [NUM_DOMAINS-1:0]    dom_rst_n_o,
   output logic [1:0]                seq_state_o
);

   localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned StgW = $clog2(STAGGER_CYCLES + 1);
   localparam int unsigned IdxW = $clog2(NUM_DOMAINS + 1);
   localparam logic [CntW-1:0] DebLast = CntW'(DEBOUNCE_CYCLES - 1);
   localparam logic [StgW-1:0] StgLast = StgW'(STAGGER_CYCLES - 1);
   localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM_DOMAINS - 1);

   typedef enum logic [1:0] {
      StReset    = 2'd0,
      StWaitLink = 2'd1,
      StRelease  = 2'd2,
      StRun      = 2'd3
   } state_e;

   // Lane map
   for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
      localparam int unsigned Src = (LANE_REVERSE != 0) ? (NUM_LANES - 1 - k) : k;
      assign rx_p_core_o[k] = rx_p_pin_i[Src];
      assign rx_n_core_o[k] = rx_n_pin_i[Src];
      assign tx_p_pin_o[k]  = tx_p_core_i[Src];
      assign tx_n_pin_o[k]  = tx_n_core_i[Src];
   end

   logic                   sync1_q, sync2_q;
   logic                   filt_q, filt_d;
   logic [CntW-1:0]        cnt_q, cnt_d;
   logic                   cattrip_q, cattrip_d;
   state_e                 state_q, state_d;
   logic [NUM_DOMAINS-1:0] dom_q, dom_d;
   logic [StgW-1:0]        stg_q, stg_d;
   logic [IdxW-1:0]        idx_q, idx_d;

   always_ff @(posedge aclk_i or negedge aresetn_i) begin
      if (!aresetn_i) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         filt_q    <= 1'b0;
         cnt_q     <= '0;
         cattrip_q <= 1'b0;
         state_q   <= StReset;
         dom_q     <= '0;
         stg_q     <= '0;
         idx_q     <= '0;
      end else begin
         sync1_q   <= perst_n_pin_i;
         sync2_q   <= sync1_q;
         filt_q    <= filt_d;
         cnt_q     <= cnt_d;
         cattrip_q <= cattrip_d;
         state_q   <= state_d;
         dom_q     <= dom_d;
         stg_q     <= stg_d;
         idx_q     <= idx_d;
      end
   end

   // Debounce: filtered value follows only after DEBOUNCE_CYCLES consecutive mismatches
   always_comb begin
      filt_d = filt_q;
      cnt_d  = '0;
      if (sync2_q != filt_q) begin
         if (cnt_q == DebLast) begin
            filt_d = sync2_q;
         end else begin
            cnt_d = cnt_q + CntW'(1);
         end
      end
   end

   // A trip in the same cycle as a clear wins
   assign cattrip_d = (|hbm_trip_i) | (cattrip_q & ~cattrip_clear_i);

   always_comb begin
      state_d = state_q;
      dom_d   = dom_q;
      stg_d   = stg_q;
      idx_d   = idx_q;
      if (!filt_q || cattrip_q) begin
         state_d = StReset;
         dom_d   = '0;
      end else begin
         case (state_q)
            StReset: begin
               state_d = StWaitLink;
               dom_d   = '0;
            end
            StWaitLink: begin
               dom_d = '0;
               if (link_up_i) begin
                  state_d = StRelease;
                  stg_d   = '0;
                  idx_d   = '0;
               end
            end
            StRelease, StRun: begin
               if (!link_up_i) begin
                  state_d = StWaitLink;
                  dom_d   = '0;
               end else if (state_q == StRelease) begin
                  // stg_q counts down the gap to the next release
                  if (stg_q == '0) begin
                     dom_d[idx_q] = 1'b1;
                     stg_d        = StgLast;
                     if (idx_q == IdxLast) begin
                        state_d = StRun;
                     end else begin
                        idx_d = idx_q + IdxW'(1);
                     end
                  end else begin
                     stg_d = stg_q - StgW'(1);
                  end
               end
            end
            default: begin
               state_d = StReset;
               dom_d   = '0;
            end
         endcase
      end
   end

   assign hbm_cattrip_o = cattrip_q;
   assign dom_rst_n_o   = dom_q;
   assign seq_state_o   = state_q;

endmodule

// File: tb/tb_pcie_board_sequencer.sv
// Randomized bench for pcie_board_sequencer against a cycle-level behavioural model.
module tb_pcie_board_sequencer;

   localparam int NL = 16;
   localparam int NH = 2;
   localparam int ND = 3;
   localparam int DB = 256;
   localparam int ST = 16;

   logic          aclk = 1'b0;
   logic          aresetn;
   logic          perst;
   logic [NL-1:0] rx_p, rx_n, tx_p, tx_n;
   logic [NL-1:0] rx_p_core, rx_n_core, tx_p_pin, tx_n_pin;
   logic          link;
   logic [NH-1:0] trip;
   logic          clr;
   logic          cattrip;
   logic [ND-1:0] dom;
   logic [1:0]    state;

   always #5 aclk = ~aclk;

   pcie_board_sequencer #(
      .NUM_LANES(NL), .LANE_REVERSE(1), .NUM_HBM_STACKS(NH), .NUM_DOMAINS(ND),
      .DEBOUNCE_CYCLES(DB), .STAGGER_CYCLES(ST)
   ) u_dut (
      .aclk_i(aclk), .aresetn_i(aresetn), .perst_n_pin_i(perst),
      .rx_p_pin_i(rx_p), .rx_n_pin_i(rx_n), .rx_p_core_o(rx_p_core), .rx_n_core_o(rx_n_core),
      .tx_p_core_i(tx_p), .tx_n_core_i(tx_n), .tx_p_pin_o(tx_p_pin), .tx_n_pin_o(tx_n_pin),
      .link_up_i(link), .hbm_trip_i(trip), .cattrip_clear_i(clr),
      .hbm_cattrip_o(cattrip), .dom_rst_n_o(dom), .seq_state_o(state)
   );

   // Four-lane instances for the explicit lane-map cases
   logic [3:0] l4_rx, l4_tx;
   logic [3:0] lr_rxp, lr_rxn, lr_txp, lr_txn, lf_rxp, lf_rxn, lf_txp, lf_txn;
   logic       lr_cat, lf_cat;
   logic [2:0] lr_dom, lf_dom;
   logic [1:0] lr_st, lf_st;

   pcie_board_sequencer #(.NUM_LANES(4), .LANE_REVERSE(1)) u_lane_rev (
      .aclk_i(aclk), .aresetn_i(aresetn), .perst_n_pin_i(1'b0),
      .rx_p_pin_i(l4_rx), .rx_n_pin_i(l4_rx), .rx_p_core_o(lr_rxp), .rx_n_core_o(lr_rxn),
      .tx_p_core_i(l4_tx), .tx_n_core_i(l4_tx), .tx_p_pin_o(lr_txp), .tx_n_pin_o(lr_txn),
      .link_up_i(1'b0), .hbm_trip_i(2'b00), .cattrip_clear_i(1'b0),
      .hbm_cattrip_o(lr_cat), .dom_rst_n_o(lr_dom), .seq_state_o(lr_st)
   );

   pcie_board_sequencer #(.NUM_LANES(4), .LANE_REVERSE(0)) u_lane_fwd (
      .aclk_i(aclk), .aresetn_i(aresetn), .perst_n_pin_i(1'b0),
      .rx_p_pin_i(l4_rx), .rx_n_pin_i(l4_rx), .rx_p_core_o(lf_rxp), .rx_n_core_o(lf_rxn),
      .tx_p_core_i(l4_tx), .tx_n_core_i(l4_tx), .tx_p_pin_o(lf_txp), .tx_n_pin_o(lf_txn),
      .link_up_i(1'b0), .hbm_trip_i(2'b00), .cattrip_clear_i(1'b0),
      .hbm_cattrip_o(lf_cat), .dom_rst_n_o(lf_dom), .seq_state_o(lf_st)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Behavioural model
   bit m_s1, m_s2, m_filt, m_cat;
   int m_run, m_state, m_rel;

   function automatic int n_released(input int rel);
      int n;
      if (rel < 1) return 0;
      n = (rel - 1) / ST + 1;
      return (n > ND) ? ND : n;
   endfunction

   function automatic logic [NL-1:0] reverse(input logic [NL-1:0] v);
      logic [NL-1:0] r;
      for (int i = 0; i < NL; i++) r[i] = v[NL-1-i];
      return r;
   endfunction

   function automatic logic [ND-1:0] exp_dom();
      if (m_state >= 2) return ND'((1 << n_released(m_rel)) - 1);
      return '0;
   endfunction

   task automatic model_reset();
      m_s1 = 0; m_s2 = 0; m_filt = 0; m_cat = 0;
      m_run = 0; m_state = 0; m_rel = 0;
   endtask

   task automatic model_step();
      bit of, oc;
      of = m_filt;
      oc = m_cat;
      if (m_s2 != m_filt) begin
         m_run++;
         if (m_run >= DB) begin
            m_filt = m_s2;
            m_run  = 0;
         end
      end else begin
         m_run = 0;
      end
      m_s2 = m_s1;
      m_s1 = perst;
      if (trip != 0)  m_cat = 1;
      else if (clr)   m_cat = 0;
      if (!of || oc) begin
         m_state = 0;
         m_rel   = 0;
      end else if (m_state == 0) begin
         m_state = 1;
      end else if (m_state == 1) begin
         if (link) begin
            m_state = 2;
            m_rel   = 0;
         end
      end else if (!link) begin
         m_state = 1;
         m_rel   = 0;
      end else begin
         m_rel++;
         if (n_released(m_rel) == ND) m_state = 3;
      end
   endtask

   // One clock: inputs held across the edge, model advanced, outputs compared at edge+1
   task automatic step();
      rx_p = NL'($urandom); rx_n = NL'($urandom);
      tx_p = NL'($urandom); tx_n = NL'($urandom);
      #1;
      check("lanes", {rx_p_core, rx_n_core, tx_p_pin, tx_n_pin},
            {reverse(rx_p), reverse(rx_n), reverse(tx_p), reverse(tx_n)});
      @(posedge aclk);
      #1;
      if (!aresetn) model_reset();
      else model_step();
      check("dom_rst_n", 64'(dom), 64'(exp_dom()));
      check("seq_state", 64'(state), 64'(m_state));
      check("cattrip", 64'(cattrip), 64'(m_cat));
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      aresetn = 1'b0; perst = 1'b1; link = 1'b1; trip = '0; clr = 1'b0;
      rx_p = '0; rx_n = '0; tx_p = '0; tx_n = '0;
      l4_rx = 4'b0001; l4_tx = 4'b0010;
      model_reset();
      run(3);
      check("lane4_rev_rx", 64'(lr_rxp), 64'(4'b1000));
      check("lane4_fwd_rx", 64'(lf_rxp), 64'(4'b0001));
      check("lane4_rev_tx", 64'(lr_txp), 64'(4'b0100));
      check("lane4_fwd_tx", 64'(lf_txp), 64'(4'b0010));
      aresetn = 1'b1;

      // Power-up sequence to RUN
      run(330);
      check("run_reached", 64'(state), 64'(3));
      // Short PERST glitch, then long PERST low and full restart
      perst = 1'b0; run(100); perst = 1'b1; run(300);
      perst = 1'b0; run(300); perst = 1'b1; run(330);
      check("rerun_reached", 64'(dom), 64'(3'b111));
      // Trip, clear during trip, clear with trip low
      trip = 2'b10; step(); trip = '0; run(5);
      trip = 2'b01; clr = 1'b1; step(); trip = '0; clr = 1'b0; run(3);
      clr = 1'b1; step(); clr = 1'b0;
      // Drop link right after the first domain release
      for (int i = 0; i < 600 && !(m_state == 2 && exp_dom() == 3'b001); i++) step();
      check("dom_001_reached", 64'(dom), 64'(3'b001));
      link = 1'b0; step();
      link = 1'b0; run(3); link = 1'b1; run(100);

      // Randomized segments
      for (int seg = 0; seg < 40; seg++) begin
         int len;
         perst = ($urandom_range(0, 4) != 0);
         link  = ($urandom_range(0, 3) != 0);
         len   = $urandom_range(1, 400);
         for (int i = 0; i < len; i++) begin
            trip = ($urandom_range(0, 199) == 0) ? NH'($urandom_range(1, 3)) : '0;
            clr  = ($urandom_range(0, 19) == 0);
            step();
         end
         trip = '0; clr = 1'b0;
         if (seg == 20) begin
            #2;
            aresetn = 1'b0;
            #1;
            check("async_rst_dom", 64'(dom), 64'(0));
            check("async_rst_state", 64'(state), 64'(0));
            check("async_rst_cattrip", 64'(cattrip), 64'(0));
            model_reset();
            run(2);
            aresetn = 1'b1;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
